// File: rtl/temp_buffer_pkg.sv
// temp_buffer_pkg
// Shared defaults and the word type for the datapath temporary buffer.
// Build option: TEMP_BUFFER_BYPASS_EN (see temp_buffer_dp.sv).
package temp_buffer_pkg;

   localparam int TEMP_WIDTH_DEFAULT = 36;
   localparam int TEMP_DEPTH_DEFAULT = 4;

   typedef logic [TEMP_WIDTH_DEFAULT-1:0] temp_word_t;

endpackage

// File: rtl/temp_buffer_valid_tracker.sv
// temp_buffer_valid_tracker
// Owns the per-entry valid bits and the occupancy count of the temp buffer.
// A bulk clear and a write in the same cycle leave only the written entry
// valid, so the count lands on exactly one.
module temp_buffer_valid_tracker
   import temp_buffer_pkg::*;
#(
   parameter int DEPTH = TEMP_DEPTH_DEFAULT,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   output logic [DEPTH-1:0] valid,
   output logic [AW:0]      occupancy
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] OCC_ONE = (AW+1)'(1);

   logic [DEPTH-1:0] r_valid;
   logic [AW:0]      r_occupancy;
   logic             w_wrInRange;
   logic             w_wrNew;

   // Qualify the write: addresses past the last entry are silently dropped,
   // and only a write into an empty entry grows the count.
   always_comb begin
      w_wrInRange = wr_en && ({1'b0, wr_addr} < DEPTH_W);
      w_wrNew     = w_wrInRange && !r_valid[wr_addr];
   end

   // Valid vector and count move together so occupancy always equals the
   // number of set bits; clear takes effect before a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid     <= '0;
         r_occupancy <= '0;
      end else if (clr) begin
         r_valid <= '0;
         if (w_wrInRange) begin
            r_valid[wr_addr] <= 1'b1;
            r_occupancy      <= OCC_ONE;
         end else begin
            r_occupancy <= '0;
         end
      end else if (w_wrInRange) begin
         r_valid[wr_addr] <= 1'b1;
         if (w_wrNew) begin
            r_occupancy <= r_occupancy + OCC_ONE;
         end
      end
   end

   assign valid     = r_valid;
   assign occupancy = r_occupancy;

endmodule

// File: rtl/temp_buffer_dp.sv
// temp_buffer_dp
// Dual-port temporary buffer between datapath passes: one write and one
// registered read per cycle, with per-entry valid tracking, bulk clear and an
// occupancy count. Reads of empty or out-of-range entries return zero as a miss.
// Build option: define TEMP_BUFFER_BYPASS_EN to forward same-cycle write data
// to a read of the same address; otherwise the read sees pre-edge state.
module temp_buffer_dp
   import temp_buffer_pkg::*;
#(
   parameter int WIDTH = TEMP_WIDTH_DEFAULT,
   parameter int DEPTH = TEMP_DEPTH_DEFAULT,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   input  logic             clr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             rd_hit,
   output logic [AW:0]      occupancy
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] w_valid;
   logic             w_wrInRange;
   logic             w_rdInRange;
   logic             w_rdHit;
   logic [WIDTH-1:0] w_rdData;
   logic             r_rdValid;
   logic             r_rdHit;
   logic [WIDTH-1:0] r_rdData;

   temp_buffer_valid_tracker #(
      .DEPTH (DEPTH)
   ) u_validTracker (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .valid     (w_valid),
      .occupancy (occupancy)
   );

   // Decide what the read port returns at the next edge: stored data only for
   // a valid in-range entry, zero otherwise, so the output never holds stale
   // data. With forwarding enabled a same-address write wins, even over clr.
   always_comb begin
      w_wrInRange = wr_en && ({1'b0, wr_addr} < DEPTH_W);
      w_rdInRange = ({1'b0, rd_addr} < DEPTH_W);
      w_rdHit     = 1'b0;
      w_rdData    = '0;
      if (rd_en && w_rdInRange && w_valid[rd_addr]) begin
         w_rdHit  = 1'b1;
         w_rdData = r_mem[rd_addr];
      end
`ifdef TEMP_BUFFER_BYPASS_EN
      if (rd_en && w_wrInRange && (rd_addr == wr_addr)) begin
         w_rdHit  = 1'b1;
         w_rdData = wr_data;
      end
`endif
   end

   // Data array has no reset so it can map onto RAM; emptiness is carried by
   // the valid bits instead.
   always_ff @(posedge clk) begin
      if (w_wrInRange) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Read pipeline register; reset discards any read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdValid <= 1'b0;
         r_rdHit   <= 1'b0;
         r_rdData  <= '0;
      end else begin
         r_rdValid <= rd_en;
         r_rdHit   <= w_rdHit;
         r_rdData  <= w_rdData;
      end
   end

   assign rd_data  = r_rdData;
   assign rd_valid = r_rdValid;
   assign rd_hit   = r_rdHit;

endmodule

// File: tb/tb_temp_buffer_dp.sv
// tb_temp_buffer_dp
// Exercises a default-size buffer (36 x 4) and a non-power-of-two one (8 x 5)
// against an array-based reference model, using directed scenarios followed by
// random traffic. Honours TEMP_BUFFER_BYPASS_EN when building expectations.
module tb_temp_buffer_dp;
   import temp_buffer_pkg::*;

   logic clk = 1'b0;
   logic rst;

   logic       aWrEn, aRdEn, aClr;
   logic [1:0] aWrAddr, aRdAddr;
   temp_word_t aWrData, aRdData;
   logic       aRdValid, aRdHit;
   logic [2:0] aOcc;

   logic       bWrEn, bRdEn, bClr;
   logic [2:0] bWrAddr, bRdAddr;
   logic [7:0] bWrData, bRdData;
   logic       bRdValid, bRdHit;
   logic [3:0] bOcc;

   logic [63:0] modelMem [2][8];
   bit          modelValid [2][8];
   bit          bypassBuild;
   int          vectorCount = 0;
   int          missCount = 0;

   // Free-running clock
   always #5 clk = ~clk;

   temp_buffer_dp dutA (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (aWrEn),
      .wr_addr   (aWrAddr),
      .wr_data   (aWrData),
      .rd_en     (aRdEn),
      .rd_addr   (aRdAddr),
      .clr       (aClr),
      .rd_data   (aRdData),
      .rd_valid  (aRdValid),
      .rd_hit    (aRdHit),
      .occupancy (aOcc)
   );

   temp_buffer_dp #(
      .WIDTH (8),
      .DEPTH (5)
   ) dutB (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (bWrEn),
      .wr_addr   (bWrAddr),
      .wr_data   (bWrData),
      .rd_en     (bRdEn),
      .rd_addr   (bRdAddr),
      .clr       (bClr),
      .rd_data   (bRdData),
      .rd_valid  (bRdValid),
      .rd_hit    (bRdHit),
      .occupancy (bOcc)
   );

   function automatic int depthOf(input int d);
      return (d == 0) ? 4 : 5;
   endfunction

   function automatic logic [63:0] maskOf(input int d);
      return (d == 0) ? 64'h0000_000F_FFFF_FFFF : 64'h0000_0000_0000_00FF;
   endfunction

   function automatic int modelOccupancy(input int d);
      int n;
      n = 0;
      for (int i = 0; i < depthOf(d); i++) n += modelValid[d][i] ? 1 : 0;
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic driveIdle();
      aWrEn = 1'b0; aWrAddr = '0; aWrData = '0; aRdEn = 1'b0; aRdAddr = '0; aClr = 1'b0;
      bWrEn = 1'b0; bWrAddr = '0; bWrData = '0; bRdEn = 1'b0; bRdAddr = '0; bClr = 1'b0;
   endtask

   // One clock of traffic on buffer d, then compare its outputs with the model
   task automatic applyStimulus(input string tag, input int d, input bit we, input int wa,
                                input logic [63:0] wdIn, input bit re, input int ra,
                                input bit clr);
      logic [63:0] wd;
      logic [63:0] expData;
      bit          expHit;
      int          depth;
      depth   = depthOf(d);
      wd      = wdIn & maskOf(d);
      expHit  = re && (ra < depth) && modelValid[d][ra];
      expData = expHit ? modelMem[d][ra] : 64'h0;
      if (bypassBuild && re && we && (wa < depth) && (wa == ra)) begin
         expHit  = 1'b1;
         expData = wd;
      end
      driveIdle();
      if (d == 0) begin
         aWrEn = we; aWrAddr = wa[1:0]; aWrData = wd[35:0];
         aRdEn = re; aRdAddr = ra[1:0]; aClr = clr;
      end else begin
         bWrEn = we; bWrAddr = wa[2:0]; bWrData = wd[7:0];
         bRdEn = re; bRdAddr = ra[2:0]; bClr = clr;
      end
      if (clr) for (int i = 0; i < 8; i++) modelValid[d][i] = 1'b0;
      if (we && (wa < depth)) begin
         modelMem[d][wa]   = wd;
         modelValid[d][wa] = 1'b1;
      end
      @(posedge clk);
      #1;
      if (d == 0) begin
         checkOutput({tag, ".rdValid"}, 64'(aRdValid), 64'(re));
         checkOutput({tag, ".rdHit"}, 64'(aRdHit), 64'(expHit));
         checkOutput({tag, ".rdData"}, 64'(aRdData), expData);
         checkOutput({tag, ".occ"}, 64'(aOcc), 64'(modelOccupancy(0)));
      end else begin
         checkOutput({tag, ".rdValid"}, 64'(bRdValid), 64'(re));
         checkOutput({tag, ".rdHit"}, 64'(bRdHit), 64'(expHit));
         checkOutput({tag, ".rdData"}, 64'(bRdData), expData);
         checkOutput({tag, ".occ"}, 64'(bOcc), 64'(modelOccupancy(1)));
      end
      driveIdle();
   endtask

   // Reset with reads and writes asserted to show reset overrides them
   task automatic resetAndCheck(input string tag);
      driveIdle();
      aRdEn = 1'b1; aWrEn = 1'b1; aWrData = 36'h1_2345_6789;
      bRdEn = 1'b1; bWrEn = 1'b1; bWrData = 8'h5A;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      driveIdle();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 8; i++) modelValid[d][i] = 1'b0;
      checkOutput({tag, ".aRdValid"}, 64'(aRdValid), 64'h0);
      checkOutput({tag, ".aRdHit"}, 64'(aRdHit), 64'h0);
      checkOutput({tag, ".aRdData"}, 64'(aRdData), 64'h0);
      checkOutput({tag, ".aOcc"}, 64'(aOcc), 64'h0);
      checkOutput({tag, ".bRdValid"}, 64'(bRdValid), 64'h0);
      checkOutput({tag, ".bRdHit"}, 64'(bRdHit), 64'h0);
      checkOutput({tag, ".bRdData"}, 64'(bRdData), 64'h0);
      checkOutput({tag, ".bOcc"}, 64'(bOcc), 64'h0);
   endtask

   // Directed scenarios first, then random traffic on both buffers
   initial begin
`ifdef TEMP_BUFFER_BYPASS_EN
      bypassBuild = 1'b1;
`else
      bypassBuild = 1'b0;
`endif
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 8; i++) begin
            modelMem[d][i]   = 64'h0;
            modelValid[d][i] = 1'b0;
         end
      rst = 1'b1;
      driveIdle();
      resetAndCheck("reset");

      for (int a = 0; a < 4; a++) applyStimulus("emptyRead", 0, 0, 0, 0, 1, a, 0);

      applyStimulus("write2", 0, 1, 2, 64'h9_ABCD_1234, 0, 0, 0);
      applyStimulus("read2", 0, 0, 0, 0, 1, 2, 0);
      applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("rewrite2", 0, 1, 2, 64'h3_0000_0001, 1, 2, 0);
      applyStimulus("readRewrite", 0, 0, 0, 0, 1, 2, 0);

      for (int a = 0; a < 4; a++) applyStimulus("fill", 0, 1, a, 64'(a + 16), 1, a, 0);
      applyStimulus("clrWrite1", 0, 1, 1, 64'h5, 1, 3, 1);
      applyStimulus("readAfterClr1", 0, 0, 0, 0, 1, 1, 0);
      applyStimulus("readAfterClr0", 0, 0, 0, 0, 1, 0, 0);

      resetAndCheck("resetBypass");
      applyStimulus("sameCycleRdWr", 0, 1, 3, 64'hF, 1, 3, 0);
      applyStimulus("readBack3", 0, 0, 0, 0, 1, 3, 0);
      applyStimulus("clrRdWr3", 0, 1, 3, 64'h7, 1, 3, 1);

      for (int n = 0; n < 300; n++)
         applyStimulus("randA", 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                       {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 15) == 0);

      applyStimulus("bWrite6", 1, 1, 6, 64'hAA, 0, 0, 0);
      applyStimulus("bRead7", 1, 0, 0, 0, 1, 7, 0);
      applyStimulus("bRead6", 1, 0, 0, 0, 1, 6, 0);
      applyStimulus("bWrite4", 1, 1, 4, 64'h3C, 0, 0, 0);
      applyStimulus("bRead4", 1, 0, 0, 0, 1, 4, 0);
      applyStimulus("bSameCycle5", 1, 1, 5, 64'h11, 1, 5, 0);

      for (int n = 0; n < 300; n++)
         applyStimulus("randB", 1, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 7), $urandom_range(0, 15) == 0);

      applyStimulus("preRstWrite", 0, 1, 0, 64'h8_8888_8888, 0, 0, 0);
      applyStimulus("preRstRead", 0, 0, 0, 0, 1, 0, 0);
      resetAndCheck("rstAfterRead");
      applyStimulus("readAfterRst", 0, 0, 0, 0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
